// File: rtl/tdm_demux_4.sv
// tdm_demux_4: receive end of a 4-channel time-division link.
// One sample per valid beat arrives in slot order 0..3; each sample is
// written to its channel's held output register. A frame-sync marker on
// slot 0 acquires lock, and SYNC_LOSS consecutive missing markers drop it.
// Optional feature: define TDM_DEMUX_PARITY_EN to add din_par / par_err
// (even parity over {din, din_par}; bad beats are not written).
module tdm_demux_4 #(
  parameter int WIDTH     = 1,
  parameter int SYNC_LOSS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             fsync,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic             din_par,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             frame_done,
  output logic             sync_err
);

  localparam int MW = $clog2(SYNC_LOSS + 1);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_out [4];
  logic [3:0]       r_out_valid;
  logic [1:0]       r_slot;
  logic [MW-1:0]    r_miss;
  logic             r_frame_done;
  logic             r_sync_err;

  // Decoded next-state values for the current beat.
  state_t           w_state_nxt;
  logic [1:0]       w_slot_nxt;
  logic [MW-1:0]    w_miss_nxt;
  logic [MW:0]      w_miss_inc;
  logic             w_take;
  logic [1:0]       w_wr_idx;
  logic             w_write;
  logic             w_frame_done;
  logic             w_sync_err;
  logic             w_par_ok;

`ifdef TDM_DEMUX_PARITY_EN
  logic r_par_err;
  assign w_par_ok = ~^{din, din_par};
`else
  assign w_par_ok = 1'b1;
`endif

  // One extra bit so miss+1 can be compared against SYNC_LOSS without wrap.
  assign w_miss_inc = {1'b0, r_miss} + (MW + 1)'(1);

  // Beat decode: where the sample goes and how slot/miss/state advance.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt  = r_state;
    w_slot_nxt   = r_slot;
    w_miss_nxt   = r_miss;
    w_take       = 1'b0;
    w_wr_idx     = r_slot;
    w_frame_done = 1'b0;
    w_sync_err   = 1'b0;
    if (din_valid) begin
      unique case (r_state)
        HUNT: begin
          // A bad-parity marker must not be trusted to acquire lock.
          if (fsync && w_par_ok) begin
            w_take      = 1'b1;
            w_wr_idx    = 2'd0;
            w_slot_nxt  = 2'd1;
            w_miss_nxt  = '0;
            w_state_nxt = LOCK;
          end
        end
        LOCK: begin
          if (fsync && (r_slot != 2'd0)) begin
            // Marker in the wrong slot: treat this beat as slot 0 and realign.
            w_take     = 1'b1;
            w_wr_idx   = 2'd0;
            w_slot_nxt = 2'd1;
            w_sync_err = 1'b1;
            w_miss_nxt = '0;
          end else if (r_slot == 2'd0) begin
            w_take   = 1'b1;
            w_wr_idx = 2'd0;
            if (fsync) begin
              w_miss_nxt = '0;
              w_slot_nxt = 2'd1;
            end else if (w_miss_inc == (MW + 1)'(SYNC_LOSS)) begin
              w_state_nxt = HUNT;
              w_slot_nxt  = 2'd0;
              w_miss_nxt  = '0;
            end else begin
              w_miss_nxt = (w_miss_inc > (MW + 1)'(SYNC_LOSS)) ? MW'(SYNC_LOSS)
                                                               : w_miss_inc[MW-1:0];
              w_slot_nxt = 2'd1;
            end
          end else begin
            w_take       = 1'b1;
            w_wr_idx     = r_slot;
            w_slot_nxt   = r_slot + 2'd1;
            w_frame_done = (r_slot == 2'd3);
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // A parity failure suppresses the write and its strobes, nothing else.
  assign w_write = w_take & w_par_ok;

  // Registered state, channel outputs and one-cycle strobes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      r_state      <= HUNT;
      r_slot       <= 2'd0;
      r_miss       <= '0;
      r_out_valid  <= 4'b0000;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      // NOTE: the channel holding registers are reset too; they are visible outputs with defined reset values.
      for (int i = 0; i < 4; i++) r_out[i] <= '0;
`ifdef TDM_DEMUX_PARITY_EN
      r_par_err    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_slot       <= w_slot_nxt;
      r_miss       <= w_miss_nxt;
      r_out_valid  <= w_write ? (4'b0001 << w_wr_idx) : 4'b0000;
      r_frame_done <= w_frame_done & w_par_ok;
      r_sync_err   <= w_sync_err;
      if (w_write) r_out[w_wr_idx] <= din;
`ifdef TDM_DEMUX_PARITY_EN
      r_par_err    <= din_valid & ~w_par_ok;
`endif
    end
  end

  assign out0       = r_out[0];
  assign out1       = r_out[1];
  assign out2       = r_out[2];
  assign out3       = r_out[3];
  assign out_valid  = r_out_valid;
  assign slot       = r_slot;
  assign locked     = (r_state == LOCK);
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err    = r_par_err;
`endif

endmodule
